mem_access: RTL and testbench

- Data-memory access stage of the 64-bit in-order pipeline. Sits directly downstream of execute and feeds writeback.
- Accepts one load, store or non-memory op per handshake from execute. Drives the data bus (dreq/dresp split address/data handshake).
- Aligns and extends load data, and returns a registered result with its writeback address.
- While an access is outstanding, holds in_ready low; the pipeline uses this as its stall.

---
 rtl/mem_access.sv | 245 ++++++++++++++++++++++++
 tb/tb_mem_access.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// mem_access: data-memory access stage of the 64-bit in-order pipeline.
//
// Takes one op per in_valid/in_ready handshake from execute. Non-memory ops
// pass in_result straight to the output. Loads and stores go out on the
// dreq/dresp split handshake: the request is held until dresp_addr_ok, and the
// data (or store completion) arrives on dresp_data_ok. Load data is shifted
// down by the byte offset and sign/zero-extended. The result, PC and writeback
// address are registered and presented with a one-cycle out_valid pulse.
// in_ready is low while an op is in flight and acts as the pipeline stall.
//
// Ports:
//   clk, reset         clock; asynchronous active-low reset
//   in_*               op from execute (valid/ready, pc, load/store, size,
//                      unsigned, addr, wdata, result, wa)
//   dreq_*             bus request (valid, addr, size, strobe, data)
//   dresp_*            bus response (addr_ok, data_ok, data)
//   out_*              registered result (valid pulse, pc, result, wa,
//                      misalign)
//
// Build option:
//   MEM_MISALIGN_TRAP_EN  defined: a misaligned load/store skips the bus and
//                         completes at once with out_misalign=1,
//                         out_result=addr and out_wa=0.
//                         undefined: out_misalign is 0 and the address low
//                         bits are forced to the size alignment.
module mem_access #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned RA_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic            in_load,
  input  logic            in_store,
  input  logic [1:0]      in_size,
  input  logic            in_unsigned,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic [XLEN-1:0] in_result,
  input  logic [RA_W-1:0] in_wa,
  output logic            dreq_valid,
  output logic [XLEN-1:0] dreq_addr,
  output logic [1:0]      dreq_size,
  output logic [7:0]      dreq_strobe,
  output logic [XLEN-1:0] dreq_data,
  input  logic            dresp_addr_ok,
  input  logic            dresp_data_ok,
  input  logic [XLEN-1:0] dresp_data,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_result,
  output logic [RA_W-1:0] out_wa,
  output logic            out_misalign
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_t;

  state_t r_state, w_state_next;

  // Latched op
  logic [XLEN-1:0] r_pc;
  logic            r_load;
  logic [1:0]      r_size;
  logic            r_unsigned;
  logic [XLEN-1:0] r_addr;
  logic [RA_W-1:0] r_wa;

  // Bus request fields, computed once at accept and held
  logic [XLEN-1:0] r_dreq_addr;
  logic [7:0]      r_dreq_strobe;
  logic [XLEN-1:0] r_dreq_data;

  // Output registers
  logic [XLEN-1:0] r_out_pc;
  logic [XLEN-1:0] r_out_result;
  logic [RA_W-1:0] r_out_wa;

  logic            w_accept;
  logic            w_mem_op;
  logic [2:0]      w_mask;
  logic            w_trap;
  logic [XLEN-1:0] w_addr_eff;
  logic [2:0]      w_off;
  logic [7:0]      w_strobe_base;
  logic [7:0]      w_strobe;
  logic [XLEN-1:0] w_wdata_sh;
  logic [XLEN-1:0] w_raw;
  logic [XLEN-1:0] w_load_val;
  logic [XLEN-1:0] w_mem_result;
  logic [XLEN-1:0] w_imm_result;
  logic            w_mem_done;

  assign w_accept = (r_state == StIdle) && in_valid;
  assign w_mem_op = in_load || in_store;

  // Low address bits that must be zero for an aligned access of this size
  always_comb begin
    w_mask = 3'b000;
    unique case (in_size)
      2'b00: w_mask = 3'b000;
      2'b01: w_mask = 3'b001;
      2'b10: w_mask = 3'b011;
      2'b11: w_mask = 3'b111;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic r_out_misalign;
  assign w_trap       = w_mem_op && ((in_addr[2:0] & w_mask) != 3'b000);
  assign w_addr_eff   = in_addr;
  assign out_misalign = r_out_misalign;
`else
  assign w_trap       = 1'b0;
  assign w_addr_eff   = {in_addr[XLEN-1:3], in_addr[2:0] & ~w_mask};
  assign out_misalign = 1'b0;
`endif

  assign w_off = w_addr_eff[2:0];

  always_comb begin
    w_strobe_base = 8'h00;
    unique case (in_size)
      2'b00: w_strobe_base = 8'h01;
      2'b01: w_strobe_base = 8'h03;
      2'b10: w_strobe_base = 8'h0F;
      2'b11: w_strobe_base = 8'hFF;
    endcase
    w_strobe = 8'h00;
    if (in_store) w_strobe = w_strobe_base << w_off;
  end

  assign w_wdata_sh = in_wdata << {w_off, 3'b000};

  // Load extraction from the raw 8-byte-aligned response
  assign w_raw = dresp_data >> {r_dreq_addr[2:0], 3'b000};

  always_comb begin
    w_load_val = w_raw;
    unique case (r_size)
      2'b00: w_load_val = {{(XLEN-8){~r_unsigned & w_raw[7]}}, w_raw[7:0]};
      2'b01: w_load_val = {{(XLEN-16){~r_unsigned & w_raw[15]}}, w_raw[15:0]};
      2'b10: w_load_val = {{(XLEN-32){~r_unsigned & w_raw[31]}}, w_raw[31:0]};
      2'b11: w_load_val = w_raw;
    endcase
  end

  // Stores report their address; writeback ignores it (wa is 0)
  assign w_mem_result = r_load ? w_load_val : r_addr;
  assign w_imm_result = w_trap ? in_addr : in_result;

  assign w_mem_done = ((r_state == StReq) && dresp_addr_ok && dresp_data_ok) ||
                      ((r_state == StWait) && dresp_data_ok);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (in_valid) w_state_next = (w_mem_op && !w_trap) ? StReq : StDone;
      end
      StReq: begin
        if (dresp_addr_ok) w_state_next = dresp_data_ok ? StDone : StWait;
      end
      StWait: begin
        if (dresp_data_ok) w_state_next = StDone;
      end
      StDone: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc          <= '0;
      r_load        <= 1'b0;
      r_size        <= 2'b00;
      r_unsigned    <= 1'b0;
      r_addr        <= '0;
      r_wa          <= '0;
      r_dreq_addr   <= '0;
      r_dreq_strobe <= 8'h00;
      r_dreq_data   <= '0;
    end else if (w_accept) begin
      r_pc          <= in_pc;
      r_load        <= in_load;
      r_size        <= in_size;
      r_unsigned    <= in_unsigned;
      r_addr        <= in_addr;
      r_wa          <= in_wa;
      r_dreq_addr   <= w_addr_eff;
      r_dreq_strobe <= w_strobe;
      r_dreq_data   <= w_wdata_sh;
    end
  end

  // Output registers change only on entry to DONE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_pc     <= '0;
      r_out_result <= '0;
      r_out_wa     <= '0;
    end else if (w_accept && !(w_mem_op && !w_trap)) begin
      r_out_pc     <= in_pc;
      r_out_result <= w_imm_result;
      r_out_wa     <= w_trap ? '0 : in_wa;
    end else if (w_mem_done) begin
      r_out_pc     <= r_pc;
      r_out_result <= w_mem_result;
      r_out_wa     <= r_wa;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_misalign <= 1'b0;
    end else if (w_accept && !(w_mem_op && !w_trap)) begin
      r_out_misalign <= w_trap;
    end else if (w_mem_done) begin
      r_out_misalign <= 1'b0;
    end
  end
`endif

  // in_ready is held low for as long as reset is asserted
  assign in_ready    = (r_state == StIdle) && reset;
  assign dreq_valid  = (r_state == StReq);
  assign dreq_addr   = r_dreq_addr;
  assign dreq_size   = r_size;
  assign dreq_strobe = r_dreq_strobe;
  assign dreq_data   = r_dreq_data;
  assign out_valid   = (r_state == StDone);
  assign out_pc      = r_out_pc;
  assign out_result  = r_out_result;
  assign out_wa      = r_out_wa;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed self-checking bench for mem_access.
// Inputs change #1 after the rising edge; outputs are sampled there too.
module tb_mem_access;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic        in_load;
  logic        in_store;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic [63:0] in_addr;
  logic [63:0] in_wdata;
  logic [63:0] in_result;
  logic [4:0]  in_wa;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [1:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [63:0] out_result;
  logic [4:0]  out_wa;
  logic        out_misalign;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_access #(.XLEN(64), .RA_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_load      (in_load),
    .in_store     (in_store),
    .in_size      (in_size),
    .in_unsigned  (in_unsigned),
    .in_addr      (in_addr),
    .in_wdata     (in_wdata),
    .in_result    (in_result),
    .in_wa        (in_wa),
    .dreq_valid   (dreq_valid),
    .dreq_addr    (dreq_addr),
    .dreq_size    (dreq_size),
    .dreq_strobe  (dreq_strobe),
    .dreq_data    (dreq_data),
    .dresp_addr_ok(dresp_addr_ok),
    .dresp_data_ok(dresp_data_ok),
    .dresp_data   (dresp_data),
    .out_valid    (out_valid),
    .out_pc       (out_pc),
    .out_result   (out_result),
    .out_wa       (out_wa),
    .out_misalign (out_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for a single accept cycle; returns #1 after the accept edge
  task automatic issue(input logic ld, input logic st, input logic [1:0] sz,
                       input logic uns, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [63:0] res,
                       input logic [4:0] wa, input logic [63:0] pc);
    in_load = ld; in_store = st; in_size = sz; in_unsigned = uns;
    in_addr = addr; in_wdata = wdata; in_result = res; in_wa = wa; in_pc = pc;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++;
      $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (dreq_valid !== 1'b0) begin n_fail++;
      $display("FAIL rst_dreq_valid: got %b want 0", dreq_valid); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++;
      $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    @(negedge clk);
    reset = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++;
      $display("FAIL rst_release_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_result !== 64'h0 || out_pc !== 64'h0 || out_wa !== 5'd0) begin n_fail++;
      $display("FAIL rst_outs: got %h/%h/%0d want 0/0/0", out_result, out_pc, out_wa); end
    n_cmp++; if (dreq_strobe !== 8'h00 || dreq_data !== 64'h0) begin n_fail++;
      $display("FAIL rst_dreq: got %h/%h want 0/0", dreq_strobe, dreq_data); end
  endtask

  task automatic test_nonmem();
    issue(1'b0, 1'b0, 2'b11, 1'b0, 64'hDEAD, 64'h0, 64'h1234, 5'd5, 64'h100);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++;
      $display("FAIL nonmem_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_result !== 64'h1234 || out_wa !== 5'd5 || out_pc !== 64'h100) begin
      n_fail++;
      $display("FAIL nonmem_out: got %h/%0d/%h want 1234/5/100", out_result, out_wa, out_pc);
    end
    n_cmp++; if (dreq_valid !== 1'b0 || in_ready !== 1'b0) begin n_fail++;
      $display("FAIL nonmem_busy: got dreq=%b rdy=%b want 0/0", dreq_valid, in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++;
      $display("FAIL nonmem_after: got ov=%b rdy=%b want 0/1", out_valid, in_ready); end
    n_cmp++; if (out_result !== 64'h1234) begin n_fail++;
      $display("FAIL nonmem_hold: got %h want 1234", out_result); end
  endtask

  task automatic test_load_byte(input logic uns, input logic [63:0] exp);
    issue(1'b1, 1'b0, 2'b00, uns, 64'h1003, 64'h0, 64'h0, 5'd9, 64'h200);
    n_cmp++; if (dreq_valid !== 1'b1 || dreq_addr !== 64'h1003 || dreq_strobe !== 8'h00 ||
                 dreq_size !== 2'b00) begin n_fail++;
      $display("FAIL lb_req: got v=%b a=%h s=%h z=%b want 1/1003/00/00",
               dreq_valid, dreq_addr, dreq_strobe, dreq_size); end
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 64'h0000_0000_8000_0000;
    tick();
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_result !== exp || out_wa !== 5'd9) begin
      n_fail++;
      $display("FAIL lb_result(uns=%b): got v=%b r=%h wa=%0d want 1/%h/9",
               uns, out_valid, out_result, out_wa, exp); end
    tick();
  endtask

  task automatic test_store_half();
    int pulses = 0;
    issue(1'b0, 1'b1, 2'b01, 1'b0, 64'h2006, 64'hABCD, 64'h0, 5'd0, 64'h300);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (dreq_valid !== 1'b1 || in_ready !== 1'b0 || dreq_strobe !== 8'hC0 ||
          dreq_data !== 64'hABCD_0000_0000_0000 || dreq_addr !== 64'h2006) begin
        n_fail++;
        $display("FAIL sh_hold[%0d]: got v=%b rdy=%b s=%h d=%h a=%h want 1/0/c0/abcd000000000000/2006",
                 i, dreq_valid, in_ready, dreq_strobe, dreq_data, dreq_addr);
      end
      tick();
    end
    dresp_addr_ok = 1'b1;
    tick();
    dresp_addr_ok = 1'b0;
    n_cmp++; if (dreq_valid !== 1'b0 || out_valid !== 1'b0) begin n_fail++;
      $display("FAIL sh_wait: got dreq=%b ov=%b want 0/0", dreq_valid, out_valid); end
    tick();
    pulses += int'(out_valid);
    dresp_data_ok = 1'b1;
    tick();
    dresp_data_ok = 1'b0;
    pulses += int'(out_valid);
    n_cmp++; if (out_result !== 64'h2006 || out_wa !== 5'd0) begin n_fail++;
      $display("FAIL sh_result: got %h/%0d want 2006/0", out_result, out_wa); end
    tick();
    pulses += int'(out_valid);
    n_cmp++; if (pulses != 1) begin n_fail++;
      $display("FAIL sh_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_load_word();
    issue(1'b1, 1'b0, 2'b10, 1'b0, 64'h3000, 64'h0, 64'h0, 5'd12, 64'h400);
    dresp_addr_ok = 1'b1;
    tick();
    dresp_addr_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++;
        $display("FAIL lw_early[%0d]: got %b want 0", i, out_valid); end
    end
    dresp_data_ok = 1'b1; dresp_data = 64'h0000_0001_7FFF_FFFF;
    tick();
    dresp_data_ok = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_result !== 64'h7FFF_FFFF || out_wa !== 5'd12) begin
      n_fail++;
      $display("FAIL lw_result: got v=%b r=%h wa=%0d want 1/7fffffff/12",
               out_valid, out_result, out_wa); end
    tick();
    dresp_data_ok = 1'b1; dresp_addr_ok = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++;
        $display("FAIL idle_spurious[%0d]: got ov=%b rdy=%b want 0/1", i, out_valid, in_ready);
      end
    end
    dresp_data_ok = 1'b0; dresp_addr_ok = 1'b0;
  endtask

  task automatic test_reset_midway();
    // Reset during REQ: request must drop at once
    issue(1'b1, 1'b0, 2'b11, 1'b0, 64'h5000, 64'h0, 64'h0, 5'd3, 64'h500);
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (dreq_valid !== 1'b0 || in_ready !== 1'b0) begin n_fail++;
      $display("FAIL rst_req: got dreq=%b rdy=%b want 0/0", dreq_valid, in_ready); end
    @(negedge clk);
    reset = 1'b1;
    tick();
    // Reset during WAIT
    issue(1'b1, 1'b0, 2'b11, 1'b0, 64'h5008, 64'h0, 64'h0, 5'd4, 64'h504);
    dresp_addr_ok = 1'b1;
    tick();
    dresp_addr_ok = 1'b0;
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (dreq_valid !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_wait: got dreq=%b rdy=%b ov=%b want 0/0/0",
               dreq_valid, in_ready, out_valid); end
    @(negedge clk);
    reset = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++;
      $display("FAIL rst_wait_ready: got %b want 1", in_ready); end
    dresp_data_ok = 1'b1; dresp_data = 64'h55;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++;
        $display("FAIL rst_late_resp[%0d]: got %b want 0", i, out_valid); end
    end
    dresp_data_ok = 1'b0;
  endtask

  task automatic test_misalign();
    issue(1'b1, 1'b0, 2'b11, 1'b0, 64'h4004, 64'h0, 64'h0, 5'd7, 64'h600);
`ifdef MEM_MISALIGN_TRAP_EN
    n_cmp++; if (out_valid !== 1'b1 || out_misalign !== 1'b1 || dreq_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_trap: got ov=%b mis=%b dreq=%b want 1/1/0",
               out_valid, out_misalign, dreq_valid); end
    n_cmp++; if (out_result !== 64'h4004 || out_wa !== 5'd0 || out_pc !== 64'h600) begin
      n_fail++;
      $display("FAIL mis_trap_out: got %h/%0d/%h want 4004/0/600", out_result, out_wa, out_pc);
    end
    tick();
`else
    n_cmp++; if (dreq_valid !== 1'b1 || dreq_addr !== 64'h4000 || dreq_size !== 2'b11) begin
      n_fail++;
      $display("FAIL mis_align_req: got v=%b a=%h z=%b want 1/4000/11",
               dreq_valid, dreq_addr, dreq_size); end
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 64'h1122_3344_5566_7788;
    tick();
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_result !== 64'h1122_3344_5566_7788 ||
                 out_misalign !== 1'b0 || out_wa !== 5'd7) begin n_fail++;
      $display("FAIL mis_align_done: got v=%b r=%h m=%b wa=%0d want 1/1122334455667788/0/7",
               out_valid, out_result, out_misalign, out_wa); end
    tick();
`endif
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_pc = '0; in_load = 1'b0; in_store = 1'b0;
    in_size = 2'b00; in_unsigned = 1'b0; in_addr = '0; in_wdata = '0;
    in_result = '0; in_wa = '0; dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    dresp_data = '0;
    test_reset();
    test_nonmem();
    test_load_byte(1'b0, 64'hFFFF_FFFF_FFFF_FF80);
    test_load_byte(1'b1, 64'h0000_0000_0000_0080);
    test_store_half();
    test_load_word();
    test_reset_midway();
    test_misalign();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
